fpga_sram_bank: RTL and testbench
=================================

# fpga_sram_bank

Parametrised, behaviourally inferred single-port SRAM bank for FPGA builds, replacing fixed-size vendor memory-generator instances. Generalises depth, data width and read latency, and emulates the ASIC macro power-gating protocol with a cycle-accurate acknowledge sequencer and optional zero-scrub of non-retained contents on wake-up. Sits wherever a memory bank is instantiated behind the system bus or the accelerator memory interconnect.

## Interface
- NumWords, 1024: words in the array; any value ≥ 2.
- DataWidth, 32: word width; must be a multiple of 8.
- ReadLatency, 1: cycles from an accepted read to rvalid_o; legal values 1 or 2.
- PwrAckDelay, 4: cycles from a power-state change request to the ack change; ≥ 1.
- AddrWidth, $clog2(NumWords): derived, do not override.
- BeWidth, DataWidth/8: derived, do not override.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AddrWidth  word address.
- wdata_i  in  DataWidth  write data.
- be_i  in  BeWidth  byte enables for writes.
- gnt_o  out  1  request accepted this cycle (combinational).
- rvalid_o  out  1  rdata_o is valid this cycle.
- rdata_o  out  DataWidth  read data.
- pwrgate_ni  in  1  0 = request power-off.
- pwrgate_ack_no  out  1  0 = bank is off; 1 = bank is on and usable.
- set_retentive_ni  in  1  0 = retain contents while off.

## Operation
- FSM states: ON, GATING, OFF, WAKING, SCRUB.
- ON: gnt_o = req_i. Granted writes update only the bytes enabled by be_i. Granted reads return mem[addr_i] after ReadLatency cycles.
- ON → GATING when pwrgate_ni = 0. set_retentive_ni is latched into a retain flag in the same cycle. gnt_o is 0 from this cycle onward.
- GATING: counts PwrAckDelay cycles, then enters OFF.
- OFF: pwrgate_ack_no = 0 and all requests are refused. OFF → WAKING when pwrgate_ni = 1.
- WAKING: counts PwrAckDelay cycles. If retain is 0 and scrubbing is compiled in, WAKING → SCRUB; otherwise WAKING → ON.
- SCRUB: writes all-zero data to addresses 0 through NumWords-1, one word per cycle, then enters ON.
- pwrgate_ni = 0 observed during WAKING or SCRUB: the sequence aborts and the FSM enters GATING with a freshly latched retain flag. The next wake restarts scrubbing at address 0.
- pwrgate_ack_no is 1 only in ON and GATING. It drops on OFF entry and rises on ON entry.
- Reads in flight when ON is left still complete normally.
- rdata_o holds its last read value until the next rvalid_o. It is never altered by writes or scrubbing.
- The read pipeline and rvalid_o accept no back-pressure.

## Timing
- Reset values: state ON, pwrgate_ack_no = 1, rvalid_o = 0, rdata_o = 0, counters 0, retain flag 0. Array contents are not cleared by reset.
- Read grant in cycle t:
  - ReadLatency = 1: rvalid_o and rdata_o in cycle t+1.
  - ReadLatency = 2: output is registered once more and appears in cycle t+2.
- Back-to-back reads run at full throughput, one per cycle.
- A write is visible to a read granted in the following cycle.
- Power-off: pwrgate_ni falls in cycle t → pwrgate_ack_no = 0 in cycle t+PwrAckDelay+1.
- Power-on: pwrgate_ni rises in cycle u, as seen in OFF:
  - Retained or scrub disabled: pwrgate_ack_no = 1 in cycle u+PwrAckDelay+1.
  - Scrubbing: pwrgate_ack_no = 1 in cycle u+PwrAckDelay+NumWords+1.
- rst_i asserted in any state returns the FSM to ON in the next cycle, aborts any scrub, and drops the in-flight rvalid_o.

## Configuration
- FPGA_SRAM_SCRUB_EN defined: the SCRUB state and address counter are built. Non-retained wake-ups zero the whole array before ON is entered.
- FPGA_SRAM_SCRUB_EN undefined: SCRUB is not built. WAKING always goes to ON and contents survive power-off regardless of set_retentive_ni. This matches FPGA BRAM behaviour and keeps legacy images working.

## Test plan
- Write 0xDEADBEEF to address 5 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read address 5 → rdata_o = 0xDEADBEAA with rvalid_o exactly ReadLatency cycles after the grant, for ReadLatency = 1 and 2.
- Issue 8 back-to-back reads to addresses 0–7 → rvalid_o high for 8 consecutive cycles, with data in address order.
- Drop pwrgate_ni with PwrAckDelay = 4 → ack low 5 cycles later, gnt_o = 0 throughout. Then raise pwrgate_ni with set_retentive_ni = 0 and scrub enabled, NumWords = 16 → ack high 21 cycles later, and every address reads 0.
- Same power sequence with set_retentive_ni = 0 during gating → the pre-gating value at address 5 still reads back after wake.
- Drop pwrgate_ni mid-scrub at scrub address 7 → ack stays low, FSM goes GATING then OFF. The next wake scrubs the full array from address 0.
- Assert rst_i during SCRUB and with a read in flight → the following cycle shows pwrgate_ack_no = 1 and rvalid_o = 0, and requests are granted immediately.

Source files
------------

// File: rtl/fpga_sram_bank.sv
// ---------------------------------------------------------------------------
// fpga_sram_bank
//
// Behaviourally inferred single-port SRAM bank for FPGA builds. Depth, word
// width and read latency are parameters. The ASIC macro power-gating
// handshake is emulated by a small sequencer that paces pwrgate_ack_no, and
// non-retained wake-ups can optionally zero the array before the bank is
// handed back.
//
// Optional feature macro: FPGA_SRAM_SCRUB_EN
//   defined   : SCRUB state and scrub address counter are built; a wake-up
//               without retention zeroes every word before ON is entered.
//   undefined : WAKING always returns to ON and contents always survive
//               power-off (plain BRAM behaviour).
//
// Parameters
//   NumWords     words in the array (>= 2)
//   DataWidth    word width, multiple of 8
//   ReadLatency  1 or 2 cycles from read grant to rvalid_o
//   PwrAckDelay  cycles from a power request to the ack change (>= 1)
//   AddrWidth    derived, do not override
//   BeWidth      derived, do not override
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   req_i             access request
//   we_i              1 = write, 0 = read
//   addr_i            word address
//   wdata_i           write data
//   be_i              byte enables for writes
//   gnt_o             request accepted this cycle (combinational)
//   rvalid_o          rdata_o valid this cycle
//   rdata_o           read data, held until the next rvalid_o
//   pwrgate_ni        0 = request power-off
//   pwrgate_ack_no    0 = bank off, 1 = bank on and usable
//   set_retentive_ni  0 = retain contents while off
// ---------------------------------------------------------------------------
module fpga_sram_bank #(
    parameter int NumWords    = 1024,
    parameter int DataWidth   = 32,
    parameter int ReadLatency = 1,
    parameter int PwrAckDelay = 4,
    parameter int AddrWidth   = $clog2(NumWords),
    parameter int BeWidth     = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    input  logic                 pwrgate_ni,
    output logic                 pwrgate_ack_no,
    input  logic                 set_retentive_ni
);

    localparam int CntWidth = (PwrAckDelay > 1) ? $clog2(PwrAckDelay) : 1;
    localparam logic [CntWidth-1:0]  CntLast    = CntWidth'(PwrAckDelay - 1);
    localparam logic [AddrWidth:0]   WordsLimit = (AddrWidth + 1)'(NumWords);
`ifdef FPGA_SRAM_SCRUB_EN
    localparam logic [AddrWidth-1:0] AddrLast   = AddrWidth'(NumWords - 1);
`endif

    typedef enum logic [2:0] {
        ST_ON,
        ST_GATING,
        ST_OFF,
        ST_WAKING
`ifdef FPGA_SRAM_SCRUB_EN
        ,
        ST_SCRUB
`endif
    } state_e;

    state_e                state_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  ack_q;
`ifdef FPGA_SRAM_SCRUB_EN
    logic                  retain_q;
    logic [AddrWidth-1:0]  scrub_addr_q;
`else
    // Retention is meaningless without scrubbing: contents always survive.
    logic                  unused_retentive;
    assign unused_retentive = set_retentive_ni;
`endif

    logic [DataWidth-1:0]  mem [NumWords];

    // -----------------------------------------------------------------------
    // Access grant and shared write port
    // -----------------------------------------------------------------------
    logic                  addr_in_range;
    logic                  rd_fire;
    logic [DataWidth-1:0]  rd_word;
    logic                  wr_en;
    logic [AddrWidth-1:0]  wr_addr;
    logic [DataWidth-1:0]  wr_data;
    logic [BeWidth-1:0]    wr_be;

    // A power-off request refuses access in the very cycle it is seen.
    assign gnt_o         = (state_q == ST_ON) && pwrgate_ni && req_i;
    assign addr_in_range = ({1'b0, addr_i} < WordsLimit);
    assign rd_fire       = gnt_o && !we_i;
    assign rd_word       = addr_in_range ? mem[addr_i] : '0;

    always_comb begin
        wr_en   = gnt_o && we_i && addr_in_range;
        wr_addr = addr_i;
        wr_data = wdata_i;
        wr_be   = be_i;
`ifdef FPGA_SRAM_SCRUB_EN
        // Scrub owns the port; no bus access can be granted outside ON.
        if (state_q == ST_SCRUB && pwrgate_ni) begin
            wr_en   = 1'b1;
            wr_addr = scrub_addr_q;
            wr_data = '0;
            wr_be   = '1;
        end
`endif
    end

    // Array is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < BeWidth; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline: ReadLatency = 2 adds one register stage in front of
    // the output register. No back-pressure.
    // -----------------------------------------------------------------------
    logic                  pipe_valid;
    logic [DataWidth-1:0]  pipe_data;

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic                 s1_valid_q;
            logic [DataWidth-1:0] s1_data_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                end else begin
                    s1_valid_q <= rd_fire;
                    if (rd_fire) begin
                        s1_data_q <= rd_word;
                    end
                end
            end

            assign pipe_valid = s1_valid_q;
            assign pipe_data  = s1_data_q;
        end else begin : g_lat1
            assign pipe_valid = rd_fire;
            assign pipe_data  = rd_word;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= pipe_valid;
            if (pipe_valid) begin
                rdata_o <= pipe_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Power sequencer. The ack only changes on OFF entry (drop) and ON entry
    // (rise), so an abort out of WAKING/SCRUB gates with the ack still low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_ON;
            cnt_q        <= '0;
            ack_q        <= 1'b1;
`ifdef FPGA_SRAM_SCRUB_EN
            retain_q     <= 1'b0;
            scrub_addr_q <= '0;
`endif
        end else begin
            case (state_q)
                ST_ON: begin
                    if (!pwrgate_ni) begin
                        state_q  <= ST_GATING;
                        cnt_q    <= '0;
`ifdef FPGA_SRAM_SCRUB_EN
                        retain_q <= ~set_retentive_ni;
`endif
                    end
                end

                ST_GATING: begin
                    if (cnt_q == CntLast) begin
                        state_q <= ST_OFF;
                        cnt_q   <= '0;
                        ack_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end

                ST_OFF: begin
                    if (pwrgate_ni) begin
                        state_q <= ST_WAKING;
                        cnt_q   <= '0;
                    end
                end

                ST_WAKING: begin
                    if (!pwrgate_ni) begin
                        state_q  <= ST_GATING;
                        cnt_q    <= '0;
`ifdef FPGA_SRAM_SCRUB_EN
                        retain_q <= ~set_retentive_ni;
`endif
                    end else if (cnt_q == CntLast) begin
                        cnt_q <= '0;
`ifdef FPGA_SRAM_SCRUB_EN
                        if (!retain_q) begin
                            state_q      <= ST_SCRUB;
                            scrub_addr_q <= '0;
                        end else begin
                            state_q <= ST_ON;
                            ack_q   <= 1'b1;
                        end
`else
                        state_q <= ST_ON;
                        ack_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end

`ifdef FPGA_SRAM_SCRUB_EN
                ST_SCRUB: begin
                    if (!pwrgate_ni) begin
                        state_q      <= ST_GATING;
                        cnt_q        <= '0;
                        retain_q     <= ~set_retentive_ni;
                        scrub_addr_q <= '0;
                    end else if (scrub_addr_q == AddrLast) begin
                        state_q      <= ST_ON;
                        ack_q        <= 1'b1;
                        scrub_addr_q <= '0;
                    end else begin
                        scrub_addr_q <= scrub_addr_q + AddrWidth'(1);
                    end
                end
`endif

                default: begin
                    state_q <= ST_ON;
                    cnt_q   <= '0;
                    ack_q   <= 1'b1;
                end
            endcase
        end
    end

    assign pwrgate_ack_no = ack_q;

endmodule

// File: tb/tb_fpga_sram_bank.sv
// ---------------------------------------------------------------------------
// tb_fpga_sram_bank
//
// Two banks (ReadLatency 1 and 2) share every input. A reference memory
// model predicts read data; each granted read pushes the expected word and
// its due cycle into a per-bank queue, and a negedge monitor pops and
// compares whenever rvalid_o is seen (or flags a missing one).
// Scrub expectations follow FPGA_SRAM_SCRUB_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpga_sram_bank;

    localparam int NW = 16;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = 4;
    localparam int D  = 4;
`ifdef FPGA_SRAM_SCRUB_EN
    localparam bit ScrubEn = 1'b1;
`else
    localparam bit ScrubEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] be = '0;
    logic          pg_n = 1'b1;
    logic          ret_n = 1'b1;

    logic          gnt1, gnt2, rv1, rv2, ack1, ack2;
    logic [DW-1:0] rd1, rd2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         q1[$];
    sb_t         q2[$];
    sb_t         e1, e2;
    logic [31:0] model [NW];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    fpga_sram_bank #(
        .NumWords(NW), .DataWidth(DW), .ReadLatency(1), .PwrAckDelay(D)
    ) dut_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt1), .rvalid_o(rv1),
        .rdata_o(rd1), .pwrgate_ni(pg_n), .pwrgate_ack_no(ack1),
        .set_retentive_ni(ret_n)
    );

    fpga_sram_bank #(
        .NumWords(NW), .DataWidth(DW), .ReadLatency(2), .PwrAckDelay(D)
    ) dut_l2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt2), .rvalid_o(rv2),
        .rdata_o(rd2), .pwrgate_ni(pg_n), .pwrgate_ack_no(ack2),
        .set_retentive_ni(ret_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnt(input logic exp);
        #1;
        check_eq("gnt_l1", 32'(gnt1), 32'(exp));
        check_eq("gnt_l2", 32'(gnt2), 32'(exp));
    endtask

    task automatic check_ack(input logic exp);
        check_eq("ack_l1", 32'(ack1), 32'(exp));
        check_eq("ack_l2", 32'(ack2), 32'(exp));
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; we = 1'b1; addr = AW'(a); wdata = d; be = b;
        check_gnt(1'b1);
        for (int i = 0; i < BW; i++) begin
            if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
        end
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input int a);
        req = 1'b1; we = 1'b0; addr = AW'(a);
        check_gnt(1'b1);
        q1.push_back('{data: model[a], due: cyc + 1});
        q2.push_back('{data: model[a], due: cyc + 2});
        tick();
        req = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < NW; i++) do_read(i);
        repeat (3) tick();
    endtask

    // Ack must fall exactly D+1 cycles after the request; access refused.
    task automatic power_off(input logic retn);
        pg_n = 1'b0; ret_n = retn; req = 1'b1; we = 1'b0; addr = '0;
        check_gnt(1'b0);
        for (int j = 1; j <= D + 1; j++) begin
            tick();
            check_gnt(1'b0);
            check_ack(j <= D);
        end
        req = 1'b0;
        repeat (2) begin
            tick();
            check_ack(1'b0);
        end
    endtask

    task automatic power_on(input bit scrub);
        int dly;
        dly = D + 1 + (scrub ? NW : 0);
        pg_n = 1'b1;
        for (int j = 1; j <= dly; j++) begin
            tick();
            check_ack(j == dly);
        end
        if (scrub) begin
            for (int i = 0; i < NW; i++) model[i] = '0;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (rv1) begin
                if (q1.size() == 0) check_eq("rv_l1_unexpected", 32'(rv1), 32'd0);
                else begin
                    e1 = q1.pop_front();
                    check_eq("rdata_l1", rd1, e1.data);
                    check_eq("lat_l1", cyc, e1.due);
                end
            end else if (q1.size() > 0 && q1[0].due <= cyc) begin
                check_eq("rv_l1_missing", 32'(rv1), 32'd1);
                e1 = q1.pop_front();
            end
            if (rv2) begin
                if (q2.size() == 0) check_eq("rv_l2_unexpected", 32'(rv2), 32'd0);
                else begin
                    e2 = q2.pop_front();
                    check_eq("rdata_l2", rd2, e2.data);
                    check_eq("lat_l2", cyc, e2.due);
                end
            end else if (q2.size() > 0 && q2[0].due <= cyc) begin
                check_eq("rv_l2_missing", 32'(rv2), 32'd1);
                e2 = q2.pop_front();
            end
        end
    end

    initial begin
        int abort_at;
        int rst_at;

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        check_ack(1'b1);
        check_eq("rv_l1_reset", 32'(rv1), 32'd0);
        check_eq("rv_l2_reset", 32'(rv2), 32'd0);
        check_eq("rd_l1_reset", rd1, 32'd0);
        check_eq("rd_l2_reset", rd2, 32'd0);
        check_gnt(1'b0);
        mon_en = 1'b1;

        // Known contents
        for (int i = 0; i < NW; i++) do_write(i, 32'hC0DE_0000 + 32'(i) * 32'h0001_0111, 4'hF);

        // Byte-enable merge, write visible to the very next read
        do_write(5, 32'hDEAD_BEEF, 4'b1111);
        do_write(5, 32'h0000_00AA, 4'b0001);
        do_read(5);
        do_write(6, 32'h1122_3344, 4'b1111);
        do_write(6, 32'hAABB_CCDD, 4'b1010);
        do_read(6);
        do_write(9, 32'hFFFF_FFFF, 4'b0000);
        do_read(9);
        repeat (3) tick();

        // Back-to-back reads 0..7
        for (int i = 0; i < 8; i++) do_read(i);
        repeat (3) tick();

        // Retained power cycle
        power_off(1'b0);
        power_on(1'b0);
        read_all();

        // Non-retained power cycle
        power_off(1'b1);
        power_on(ScrubEn);
        read_all();

        // Abort mid-wake (scrub address 7 when scrubbing is built)
        for (int i = 0; i < NW; i++) do_write(i, 32'h5A00_0000 | 32'(i + 1), 4'hF);
        power_off(1'b1);
        abort_at = ScrubEn ? D + 8 : 2;
        pg_n = 1'b1;
        for (int j = 1; j <= abort_at; j++) begin
            tick();
            check_ack(1'b0);
        end
        pg_n = 1'b0;
        for (int j = 1; j <= D + 3; j++) begin
            tick();
            check_ack(1'b0);
        end
        power_on(ScrubEn);
        read_all();

        // Reset with a read in flight: latency-2 result is dropped
        do_write(9, 32'h0BAD_F00D, 4'hF);
        do_read(9);
        rst = 1'b1;
        while (q1.size() > 0 && q1[$].due > cyc) e1 = q1.pop_back();
        while (q2.size() > 0 && q2[$].due > cyc) e2 = q2.pop_back();
        tick();
        rst = 1'b0;
        check_ack(1'b1);
        check_eq("rv_l2_after_rst", 32'(rv2), 32'd0);
        do_read(9);
        repeat (3) tick();

        // Reset during scrub (during wake when scrubbing is not built)
        power_off(1'b1);
        rst_at = ScrubEn ? D + 3 : D - 1;
        pg_n = 1'b1;
        for (int j = 1; j <= rst_at; j++) begin
            tick();
            check_ack(1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_ack(1'b1);
        check_eq("rv_l1_after_rst2", 32'(rv1), 32'd0);
        do_write(2, 32'h1357_9BDF, 4'hF);
        do_read(2);
        repeat (4) tick();

        check_eq("sb_empty_l1", 32'(q1.size()), 32'd0);
        check_eq("sb_empty_l2", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
